// File: rtl/lsu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : lsu_pkg                                                   |
// | Purpose  : Shared RV32I load/store funct3 encodings and the LSU      |
// |            controller state type.                                    |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package lsu_pkg;

   // Load encodings
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   // Store encodings (share values with the signed loads)
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : lsu_align                                                 |
// | Purpose  : Combinational byte-lane logic for the LSU: store strobes, |
// |            lane-replicated store data, extended load data and the    |
// |            misaligned / illegal-funct3 error flag.                   |
// | Ports    : we_i, funct3_i, addr_lo_i  - operation descriptor         |
// |            wdata_i                    - raw store data (rs2)         |
// |            rdata_i                    - raw memory word              |
// |            wstrb_o, wdata_o           - memory-side store lanes      |
// |            rdata_o                    - extended load result         |
// |            err_o                      - op cannot be issued          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module lsu_align
   import lsu_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   logic [31:0] sel;

   always_comb begin
      wstrb_o = 4'b0000;
      wdata_o = wdata_i;
      rdata_o = 32'd0;
      err_o   = 1'b0;
      // Bring the addressed byte/halfword down to bit 0.
      sel     = rdata_i >> {addr_lo_i, 3'b000};

      if (we_i) begin
         case (funct3_i)
            SB: begin
               wstrb_o = 4'b0001 << addr_lo_i;
               wdata_o = {4{wdata_i[7:0]}};
            end
            SH: begin
               wstrb_o = 4'b0011 << addr_lo_i;
               wdata_o = {2{wdata_i[15:0]}};
               err_o   = addr_lo_i[0];
            end
            SW: begin
               wstrb_o = 4'b1111;
               err_o   = |addr_lo_i;
            end
            default: err_o = 1'b1;
         endcase
      end else begin
         case (funct3_i)
            LB:  rdata_o = {{24{sel[7]}}, sel[7:0]};
            LH: begin
               rdata_o = {{16{sel[15]}}, sel[15:0]};
               err_o   = addr_lo_i[0];
            end
            LW: begin
               rdata_o = sel;
               err_o   = |addr_lo_i;
            end
            LBU: rdata_o = {24'd0, sel[7:0]};
            LHU: begin
               rdata_o = {16'd0, sel[15:0]};
               err_o   = addr_lo_i[0];
            end
            default: err_o = 1'b1;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : lsu                                                       |
// | Purpose  : Multi-cycle load/store unit. Accepts one memory op from   |
// |            the EXU, issues a single word-aligned transaction on the  |
// |            data-memory port and returns an extended load result or   |
// |            a store completion to writeback.                          |
// | Ports    : clk_i, rst_ni (async, active-low)                         |
// |            in_*   - EXU request (valid/ready, we, funct3, addr, data)|
// |            mem_*  - data-memory req/gnt and rvalid/rdata port        |
// |            out_*  - one-cycle completion pulse, data, error          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              in_we_i,
   input  logic [2:0]        in_funct3_i,
   input  logic [ADDR_W-1:0] in_addr_i,
   input  logic [31:0]       in_wdata_i,
   output logic              mem_req_o,
   input  logic              mem_gnt_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_wstrb_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i,
   output logic              out_valid_o,
   output logic [31:0]       out_rdata_o,
   output logic              out_err_o
);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              is_idle;
   logic              al_we;
   logic [2:0]        al_funct3;
   logic [1:0]        al_addr_lo;
   logic [31:0]       al_wdata;
   logic [3:0]        al_wstrb;
   logic [31:0]       al_lane_wdata;
   logic [31:0]       al_rdata;
   logic              al_err;

   assign is_idle = (state_q == IDLE);

   // In IDLE the aligner looks at the incoming op so the accept decision
   // (issue vs. error) is known in the same cycle; afterwards it works on
   // the latched op, which keeps the memory-side outputs stable in REQ.
   assign al_we      = is_idle ? in_we_i          : we_q;
   assign al_funct3  = is_idle ? in_funct3_i      : funct3_q;
   assign al_addr_lo = is_idle ? in_addr_i[1:0]   : addr_q[1:0];
   assign al_wdata   = is_idle ? in_wdata_i       : wdata_q;

   lsu_align u_align (
      .we_i      (al_we),
      .funct3_i  (al_funct3),
      .addr_lo_i (al_addr_lo),
      .wdata_i   (al_wdata),
      .rdata_i   (mem_rdata_i),
      .wstrb_o   (al_wstrb),
      .wdata_o   (al_lane_wdata),
      .rdata_o   (al_rdata),
      .err_o     (al_err)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               we_d     = in_we_i;
               funct3_d = in_funct3_i;
               addr_d   = in_addr_i;
               wdata_d  = in_wdata_i;
               // Result registers are cleared on accept so stores and
               // errors report zero data.
               rdata_d  = 32'd0;
               err_d    = al_err;
               state_d  = al_err ? DONE : REQ;
            end
         end
         REQ: begin
            if (mem_gnt_i) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rvalid_i) begin
               if (!we_q) rdata_d = al_rdata;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready_o  = is_idle;
   assign mem_req_o   = (state_q == REQ);
   assign mem_we_o    = mem_req_o & we_q;
   assign mem_addr_o  = mem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_wstrb_o = mem_we_o ? al_wstrb : 4'b0000;
   assign mem_wdata_o = mem_we_o ? al_lane_wdata : 32'd0;
   assign out_valid_o = (state_q == DONE);
   assign out_rdata_o = rdata_q;
   assign out_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : tb_lsu                                                    |
// | Purpose  : Directed self-checking bench for lsu with a scoreboard of |
// |            expected completions.                                     |
// | Ports    : none                                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_we;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic        mem_req, mem_gnt, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic [31:0] out_rdata;
   logic        out_err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   lsu #(.ADDR_W(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_we_i      (in_we),
      .in_funct3_i  (in_funct3),
      .in_addr_i    (in_addr),
      .in_wdata_i   (in_wdata),
      .mem_req_o    (mem_req),
      .mem_gnt_i    (mem_gnt),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wstrb_o  (mem_wstrb),
      .mem_wdata_o  (mem_wdata),
      .mem_rvalid_i (mem_rvalid),
      .mem_rdata_i  (mem_rdata),
      .out_valid_o  (out_valid),
      .out_rdata_o  (out_rdata),
      .out_err_o    (out_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: every completion pulse must match the oldest
   // expectation pushed when the op was driven.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected out_valid", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb out_rdata", out_rdata, mon_e.rdata);
            chk("sb out_err", 32'(out_err), 32'(mon_e.err));
         end
      end
   end

   task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rword, input int stall, input int rvwait,
                         input logic exp_err, input logic [31:0] exp_rd,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wd);
      logic [31:0] exp_addr;
      exp_addr = {addr[31:2], 2'b00};
      @(negedge clk);
      chk({tag, " ready before"}, 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_we     = we;
      in_funct3 = f3;
      in_addr   = addr;
      in_wdata  = wd;
      sb_q.push_back({exp_err, exp_rd});
      @(posedge clk);
      #1;
      // Scramble inputs to show the op was latched.
      in_valid  = 1'b0;
      in_we     = ~we;
      in_funct3 = 3'b111;
      in_addr   = $urandom;
      in_wdata  = $urandom;
      if (exp_err) begin
         @(negedge clk);
         chk({tag, " err no req"}, 32'(mem_req), 32'd0);
         chk({tag, " err valid N+1"}, 32'(out_valid), 32'd1);
         chk({tag, " err ready low"}, 32'(in_ready), 32'd0);
      end else begin
         for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            chk({tag, " req"}, 32'(mem_req), 32'd1);
            chk({tag, " req we"}, 32'(mem_we), 32'(we));
            chk({tag, " req addr"}, mem_addr, exp_addr);
            chk({tag, " req wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
            chk({tag, " req wdata"}, mem_wdata, exp_wd);
            chk({tag, " req ready low"}, 32'(in_ready), 32'd0);
            chk({tag, " req no valid"}, 32'(out_valid), 32'd0);
            if (s == stall) mem_gnt = 1'b1;
            @(posedge clk);
            #1 mem_gnt = 1'b0;
         end
         for (int r = 0; r <= rvwait; r++) begin
            @(negedge clk);
            chk({tag, " wait no req"}, 32'(mem_req), 32'd0);
            chk({tag, " wait no valid"}, 32'(out_valid), 32'd0);
            if (r == rvwait) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rword;
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
         end
         @(negedge clk);
         chk({tag, " done valid"}, 32'(out_valid), 32'd1);
         chk({tag, " done ready low"}, 32'(in_ready), 32'd0);
         chk({tag, " done no req"}, 32'(mem_req), 32'd0);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({tag, " single pulse"}, 32'(out_valid), 32'd0);
      chk({tag, " ready after"}, 32'(in_ready), 32'd1);
      chk({tag, " rdata held"}, out_rdata, exp_rd);
      chk({tag, " err held"}, 32'(out_err), 32'(exp_err));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_we      = 1'b0;
      in_funct3  = 3'd0;
      in_addr    = 32'd0;
      in_wdata   = 32'd0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;

      #2;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset mem_we", 32'(mem_we), 32'd0);
      chk("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset mem_wdata", mem_wdata, 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_rdata", out_rdata, 32'd0);
      chk("reset out_err", 32'(out_err), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      //       tag      we    f3      addr          wdata         rword       st rv err exp_rd        strb     exp_wd
      run_op("lb",   1'b0, LB,     32'h8000_0003, 32'h0,        32'h80FF_1234, 0, 0, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0);
      run_op("lhu",  1'b0, LHU,    32'h8000_0002, 32'h0,        32'h8001_0000, 0, 0, 1'b0, 32'h0000_8001, 4'b0000, 32'h0);
      run_op("lh",   1'b0, LH,     32'h8000_0002, 32'h0,        32'h8001_0000, 0, 0, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0);
      run_op("sb",   1'b1, SB,     32'h8000_0001, 32'h0000_00AB, 32'h5555_5555, 0, 0, 1'b0, 32'h0,        4'b0010, 32'hABAB_ABAB);
      run_op("lwmis",1'b0, LW,     32'h8000_0006, 32'h0,        32'h0,         0, 0, 1'b1, 32'h0,        4'b0000, 32'h0);
      run_op("ld011",1'b0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,         0, 0, 1'b1, 32'h0,        4'b0000, 32'h0);
      run_op("shmis",1'b1, SH,     32'h8000_0001, 32'h1234_5678, 32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0);
      run_op("st100",1'b1, 3'b100, 32'h8000_0000, 32'h1234_5678, 32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0);
      run_op("sh",   1'b1, SH,     32'h8000_0022, 32'h1234_5678, 32'h0,        0, 1, 1'b0, 32'h0,        4'b1100, 32'h5678_5678);
      run_op("sw",   1'b1, SW,     32'h8000_0010, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4, 2, 1'b0, 32'h0,        4'b1111, 32'hDEAD_BEEF);
      run_op("lbu",  1'b0, LBU,    32'h8000_0001, 32'h0,        32'h1234_F0AB, 1, 0, 1'b0, 32'h0000_00F0, 4'b0000, 32'h0);

      // Reset while a load is waiting for its data.
      @(negedge clk);
      in_valid  = 1'b1;
      in_we     = 1'b0;
      in_funct3 = LW;
      in_addr   = 32'h8000_0008;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("rst-test req", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1;
      @(posedge clk);
      #1 mem_gnt = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      chk("midrst mem_req", 32'(mem_req), 32'd0);
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst out_rdata", out_rdata, 32'd0);
      chk("midrst out_err", 32'(out_err), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_CAFE;
      @(posedge clk);
      #1 mem_rvalid = 1'b0;
      @(negedge clk);
      chk("late rvalid no valid", 32'(out_valid), 32'd0);
      chk("late rvalid ready", 32'(in_ready), 32'd1);
      chk("late rvalid rdata", out_rdata, 32'd0);

      run_op("lw",   1'b0, LW,     32'h8000_0004, 32'h0,        32'h1122_3344, 0, 0, 1'b0, 32'h1122_3344, 4'b0000, 32'h0);

      chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Multi-cycle load/store unit sitting directly downstream of the EXU: takes the ALU-computed address, store data and funct3 of a memory instruction, runs one transaction on a variable-latency data-memory port, and returns a sign/zero-extended load result (or a store completion) to writeback. Handles byte-lane alignment, write strobes, misalignment and illegal-width detection, so the EXU and data memory only see word-aligned 32-bit traffic.

## Interface
- ADDR_W, 32, address width (data width fixed at 32)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- in_valid  in  1  EXU presents a memory op
- in_ready  out  1  LSU can accept; equals (state == IDLE)
- in_we  in  1  1 = store, 0 = load
- in_funct3  in  3  RV32I load/store funct3
- in_addr  in  ADDR_W  byte address (ALUResult)
- in_wdata  in  32  store data (rs2)
- mem_req  out  1  memory request
- mem_gnt  in  1  request accepted this cycle
- mem_we  out  1  request is a write
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}
- mem_wstrb  out  4  byte enables (0 for loads)
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data / write ack
- mem_rdata  in  32  raw word
- out_valid  out  1  one-cycle completion pulse
- out_rdata  out  32  extended load data (0 for stores/errors)
- out_err  out  1  misaligned or illegal funct3, valid with out_valid

## Operation
- Handshake: transfer when in_valid && in_ready; we/funct3/addr/wdata latched into registers; inputs ignored otherwise.
- Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; legal stores: 000 sb, 001 sh, 010 sw; anything else → err.
- Misaligned: halfword with addr[0]=1, word with addr[1:0]≠0 → err.
- States: IDLE → (accept, no err) REQ; IDLE → (accept, err) DONE; REQ → (mem_gnt) WAIT; WAIT → (mem_rvalid) DONE; DONE → IDLE unconditionally.
- REQ: mem_req=1 with stable mem_we/addr/wstrb/wdata until mem_gnt; all mem_* outputs 0 outside REQ.
- Stores: wstrb sb = 4'b0001<<addr[1:0], sh = 4'b0011<<addr[1:0], sw = 4'b1111; wdata sb = {4{wdata[7:0]}}, sh = {2{wdata[15:0]}}, sw = wdata. Store completes on mem_rvalid (write ack); rdata ignored.
- Loads: sel = mem_rdata >> (8*addr[1:0]); lb/lh sign-extend bit 7/15, lbu/lhu zero-extend, lw unchanged. Result registered on mem_rvalid in WAIT.
- Errors issue no memory request; out_rdata=0, out_err=1.
- out_rdata/out_err hold until next accept; out_valid only in DONE.
- mem_rvalid in IDLE/REQ/DONE ignored (memory must not return before the cycle after gnt).

## Timing
- Reset (reset=0): state IDLE, in_ready=1, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, out_valid=0, out_rdata=0, out_err=0.
- Reset mid-transaction: immediate return to IDLE, no out_valid; data memory is reset on the same signal.
- Accept at edge N: mem_req high cycle N+1; gnt in N+1 and rvalid in N+2 → out_valid cycle N+3 (minimum 3-cycle latency). Error path: out_valid cycle N+1.
- Each gnt stall or rvalid wait cycle adds one cycle; no timeout.
- Throughput: one op per ≥ (latency+1) cycles; in_ready low from N+1 through DONE cycle.

## Structure
- Package lsu_pkg: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), state enum {IDLE, REQ, WAIT, DONE}.
- Sub-module lsu_align (combinational): latched funct3/addr/wdata/mem_rdata → wstrb, lane wdata, extended load data, err flag. lsu holds FSM and registers.

## Test plan
- lb addr 0x80000003, mem_rdata 0x80FF1234, gnt and rvalid immediate → out_valid cycle N+3, out_rdata 0xFFFFFF80, out_err 0.
- lhu addr 0x80000002, mem_rdata 0x8001_0000 → out_rdata 0x00008001; lh same → 0xFFFF8001.
- sb addr 0x80000001, in_wdata 0x000000AB → mem_wstrb 4'b0010, mem_wdata 0xABABABAB, mem_addr 0x80000000; rvalid ack → out_valid, out_rdata 0.
- lw addr 0x80000006 → no mem_req, out_valid cycle N+1, out_err 1; funct3 011 load → same.
- sw with mem_gnt held low 4 cycles, rvalid 3 cycles later → mem_req/addr/strb stable throughout, out_valid exactly once, in_ready 0 until DONE passes.
- reset pulled low while in WAIT → outputs to reset values, late mem_rvalid ignored, next op completes normally.
